// File: rtl/kuznechik_key_scheduler_if.sv
// kuznechik_key_scheduler_if: one round-key read port (request, grant, registered response)
interface kuznechik_key_scheduler_if;
  logic         req;
  logic [3:0]   idx;
  logic         gnt;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         rd_err;
  modport master (output req, idx, input gnt, rd_valid, rd_key, rd_err);
  modport slave (input req, idx, output gnt, rd_valid, rd_key, rd_err);
endinterface

// File: rtl/kuznechik_key_scheduler.sv
// kuznechik_key_scheduler: drives keygen, stores 10 round keys, serves two round-robin read ports
module kuznechik_key_scheduler (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [255:0]               master_key,
  output logic                       busy,
  output logic                       done,
  output logic                       keys_valid,
  output logic                       kg_rst_n,
  output logic [255:0]               kg_master_key,
  output logic                       kg_en,
  input  logic [255:0]               kg_round_keys,
  input  logic                       kg_ready,
  kuznechik_key_scheduler_if.slave   port_a,
  kuznechik_key_scheduler_if.slave   port_b
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [2:0] p;
  logic ptr;
  logic [127:0] store [10];
  logic acc, wr, last, ga, gb, va, vb, ea, eb;
  logic [127:0] ka, kb;
  always_comb begin
    acc = start && (state == IDLE || state == DONE);
    wr = kg_ready && state == RUN;
    last = wr && p == 3'd4;
    state_n = acc ? LOAD : state == LOAD ? RUN : last ? DONE : state;
    busy = state == LOAD || state == RUN;
    kg_rst_n = state == RUN || state == DONE;
    kg_en = state == RUN;
    ga = keys_valid && port_a.req && (!port_b.req || !ptr);
    gb = keys_valid && port_b.req && (!port_a.req || ptr);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      p <= '0;
      ptr <= 1'b0;
      keys_valid <= 1'b0;
      done <= 1'b0;
      kg_master_key <= '0;
      va <= 1'b0;
      vb <= 1'b0;
      ea <= 1'b0;
      eb <= 1'b0;
      ka <= '0;
      kb <= '0;
    end else begin
      done <= last;
      if (acc) kg_master_key <= master_key;
      keys_valid <= acc ? 1'b0 : last ? 1'b1 : keys_valid;
      p <= state == LOAD ? 3'd0 : wr ? p + 3'd1 : p;
      if (keys_valid && port_a.req && port_b.req) ptr <= ~ptr;
      va <= ga;
      vb <= gb;
      if (ga) begin
        ka <= port_a.idx < 4'd10 ? store[port_a.idx] : '0;
        ea <= port_a.idx >= 4'd10;
      end
      if (gb) begin
        kb <= port_b.idx < 4'd10 ? store[port_b.idx] : '0;
        eb <= port_b.idx >= 4'd10;
      end
    end
  always_ff @(posedge clk)
    if (!rst && wr) begin
      store[{p, 1'b0}] <= kg_round_keys[255:128];
      store[{p, 1'b1}] <= kg_round_keys[127:0];
    end
  assign port_a.gnt = ga;
  assign port_b.gnt = gb;
  assign port_a.rd_valid = va;
  assign port_b.rd_valid = vb;
  assign port_a.rd_key = ka;
  assign port_b.rd_key = kb;
  assign port_a.rd_err = ea;
  assign port_b.rd_err = eb;
endmodule

// File: tb/tb_kuznechik_key_scheduler.sv
// tb_kuznechik_key_scheduler: directed self-checking bench acting as keygen and both requesters
module tb_kuznechik_key_scheduler;
  logic clk = 1'b0;
  logic rst, start, kg_ready;
  logic [255:0] master_key, kg_round_keys;
  logic busy, done, keys_valid, kg_rst_n, kg_en;
  logic [255:0] kg_master_key;
  logic [127:0] rk [10];
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [255:0] GOST = 256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [255:0] OTHER = 256'h0123456789abcdef0123456789abcdef_00112233445566778899aabbccddeeff;
  kuznechik_key_scheduler_if ia ();
  kuznechik_key_scheduler_if ib ();
  kuznechik_key_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .master_key(master_key),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .kg_rst_n(kg_rst_n), .kg_master_key(kg_master_key), .kg_en(kg_en),
    .kg_round_keys(kg_round_keys), .kg_ready(kg_ready),
    .port_a(ia), .port_b(ib)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic feed_pair(input int i, input int gap);
    repeat (gap) tick;
    kg_ready = 1'b1;
    kg_round_keys = {rk[2*i], rk[2*i+1]};
    tick;
    kg_ready = 1'b0;
    kg_round_keys = '0;
  endtask
  task automatic start_key(input logic [255:0] k);
    master_key = k;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic rd(input bit side, input logic [3:0] idx, input logic [127:0] k, input logic e);
    string s;
    s = $sformatf("%s idx%0d", side ? "b" : "a", idx);
    if (side) begin ib.req = 1'b1; ib.idx = idx; end
    else begin ia.req = 1'b1; ia.idx = idx; end
    #1;
    chk({s, " gnt"}, side ? ib.gnt : ia.gnt, 1);
    tick;
    ia.req = 1'b0;
    ib.req = 1'b0;
    chk({s, " rd_valid"}, side ? ib.rd_valid : ia.rd_valid, 1);
    chk({s, " rd_key"}, side ? ib.rd_key : ia.rd_key, k);
    chk({s, " rd_err"}, side ? ib.rd_err : ia.rd_err, e);
    tick;
    chk({s, " valid_drop"}, side ? ib.rd_valid : ia.rd_valid, 0);
    chk({s, " key_hold"}, side ? ib.rd_key : ia.rd_key, k);
  endtask
  initial begin
    rk[0] = 128'h8899aabbccddeeff0011223344556677;
    rk[1] = 128'hfedcba98765432100123456789abcdef;
    rk[2] = 128'hdb31485315694343228d6aef8cc78c44;
    rk[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    rk[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
    rk[5] = 128'hbd079435165c6432b532e82834da581b;
    rk[6] = 128'h51e640757e8745de705727265a0098b1;
    rk[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
    rk[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
    rk[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
    rst = 1'b1;
    start = 1'b0;
    kg_ready = 1'b0;
    master_key = '0;
    kg_round_keys = '0;
    ia.req = 1'b0;
    ia.idx = '0;
    ib.req = 1'b0;
    ib.idx = '0;
    repeat (2) tick;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst keys_valid", keys_valid, 0);
    chk("rst kg_rst_n", kg_rst_n, 0);
    chk("rst kg_en", kg_en, 0);
    chk("rst kg_master_key", kg_master_key, 0);
    chk("rst rd_valid_a", ia.rd_valid, 0);
    chk("rst rd_key_a", ia.rd_key, 0);
    chk("rst rd_key_b", ib.rd_key, 0);
    chk("rst rd_err_b", ib.rd_err, 0);
    rst = 1'b0;
    start_key(GOST);
    chk("load busy", busy, 1);
    chk("load kg_rst_n", kg_rst_n, 0);
    chk("load kg_en", kg_en, 0);
    chk("load kg_master_key", kg_master_key, GOST);
    kg_ready = 1'b1;
    kg_round_keys = '1;
    tick;
    kg_ready = 1'b0;
    kg_round_keys = '0;
    chk("run kg_en", kg_en, 1);
    chk("run kg_rst_n", kg_rst_n, 1);
    chk("run busy", busy, 1);
    for (int i = 0; i < 4; i++) feed_pair(i, 2);
    chk("run done low", done, 0);
    ia.req = 1'b1;
    ia.idx = 4'd1;
    #1;
    chk("blocked gnt_a", ia.gnt, 0);
    feed_pair(4, 1);
    chk("done pulse", done, 1);
    chk("keys_valid rise", keys_valid, 1);
    chk("done busy", busy, 0);
    chk("done kg_en", kg_en, 0);
    chk("done kg_rst_n", kg_rst_n, 1);
    chk("gnt_a at valid rise", ia.gnt, 1);
    tick;
    ia.req = 1'b0;
    chk("done one cycle", done, 0);
    chk("blocked rd_valid_a", ia.rd_valid, 1);
    chk("blocked rd_key_a", ia.rd_key, rk[1]);
    kg_ready = 1'b1;
    kg_round_keys = '1;
    tick;
    kg_ready = 1'b0;
    kg_round_keys = '0;
    rd(0, 4'd0, rk[0], 0);
    rd(0, 4'd1, rk[1], 0);
    rd(1, 4'd2, rk[2], 0);
    rd(0, 4'd3, rk[3], 0);
    rd(1, 4'd9, rk[9], 0);
    rd(1, 4'd12, '0, 1);
    rd(0, 4'd10, '0, 1);
    ia.req = 1'b1;
    ia.idx = 4'd0;
    ib.req = 1'b1;
    ib.idx = 4'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d gnt_a", i), ia.gnt, (i % 2 == 0));
      chk($sformatf("cont%0d gnt_b", i), ib.gnt, (i % 2 == 1));
      tick;
      chk($sformatf("cont%0d rd_valid_a", i), ia.rd_valid, (i % 2 == 0));
      chk($sformatf("cont%0d rd_valid_b", i), ib.rd_valid, (i % 2 == 1));
      if (i % 2 == 0) chk($sformatf("cont%0d rd_key_a", i), ia.rd_key, rk[0]);
      else chk($sformatf("cont%0d rd_key_b", i), ib.rd_key, rk[9]);
    end
    ia.req = 1'b0;
    ib.req = 1'b0;
    tick;
    start_key(GOST);
    chk("restart keys_valid drop", keys_valid, 0);
    chk("restart busy", busy, 1);
    tick;
    master_key = OTHER;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("ignored start busy", busy, 1);
    chk("ignored start kg_en", kg_en, 1);
    chk("ignored start key", kg_master_key, GOST);
    for (int i = 0; i < 5; i++) feed_pair(i, 1);
    chk("second done", done, 1);
    rd(0, 4'd4, rk[4], 0);
    rd(1, 4'd7, rk[7], 0);
    start_key(GOST);
    tick;
    feed_pair(0, 1);
    feed_pair(1, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst keys_valid", keys_valid, 0);
    chk("midrst kg_rst_n", kg_rst_n, 0);
    chk("midrst busy", busy, 0);
    chk("midrst kg_master_key", kg_master_key, 0);
    chk("midrst rd_key_a", ia.rd_key, 0);
    ia.req = 1'b1;
    ia.idx = 4'd0;
    #1;
    chk("midrst gnt_a", ia.gnt, 0);
    ia.req = 1'b0;
    start_key(GOST);
    tick;
    for (int i = 0; i < 5; i++) feed_pair(i, 3);
    chk("fresh done", done, 1);
    for (int i = 0; i < 10; i++) rd(i[0], i[3:0], rk[i], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
